// File: rtl/pool2d_pkg.sv
// pool2d_pkg
//   Shared definitions for the 2x2 stride-2 pooling stream engine:
//   control FSM state encoding, APB register offsets, pooling mode
//   encodings and the frame-geometry validity check.
package pool2d_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   // APB register offsets (PADDR[7:0])
   localparam logic [7:0] REG_CTRL   = 8'h00;
   localparam logic [7:0] REG_WIDTH  = 8'h04;
   localparam logic [7:0] REG_HEIGHT = 8'h08;
   localparam logic [7:0] REG_STATUS = 8'h0C;
   localparam logic [7:0] REG_CYCLES = 8'h10;

   // CTRL.MODE encodings
   localparam logic MODE_MAX = 1'b0;
   localparam logic MODE_AVG = 1'b1;

   // A frame is usable when both dimensions are even and nonzero and the
   // row fits in the line buffer.
   function automatic logic cfg_valid(input logic [15:0] w,
                                      input logic [15:0] h,
                                      input logic [15:0] max_w);
      return (w != 16'd0) && !w[0] && (w <= max_w) &&
             (h != 16'd0) && !h[0];
   endfunction

endpackage

// File: rtl/pool2d_lane.sv
// pool2d_lane
//   Per-lane arithmetic of the 2x2 pooling window, purely combinational.
//   The horizontal pair (a_i, b_i) is first reduced to a partial value
//   (max, or sum) that is ELEM_W+2 bits wide so it can be stored in the
//   line buffer. On odd rows that partial is combined with the stored
//   partial of the row above to form the final element.
//
// Ports
//   mode_i  : 0 = max pooling, 1 = average pooling
//   a_i     : signed element, even column
//   b_i     : signed element, odd column
//   lb_i    : partial read from the line buffer (row above)
//   pair_o  : partial of the current column pair (line-buffer write data)
//   out_o   : final pooled element (valid on odd rows)
module pool2d_lane
   import pool2d_pkg::*;
#(
   parameter int ELEM_W = 8
)(
   input  logic              mode_i,
   input  logic [ELEM_W-1:0] a_i,
   input  logic [ELEM_W-1:0] b_i,
   input  logic [ELEM_W+1:0] lb_i,
   output logic [ELEM_W+1:0] pair_o,
   output logic [ELEM_W-1:0] out_o
);

   logic signed [ELEM_W+1:0] a_ext;
   logic signed [ELEM_W+1:0] b_ext;
   logic signed [ELEM_W+1:0] lb_s;
   logic signed [ELEM_W+1:0] pair_s;
   logic signed [ELEM_W+1:0] tot_s;
   logic signed [ELEM_W+1:0] res_s;

   always_comb begin
      a_ext = {{2{a_i[ELEM_W-1]}}, a_i};
      b_ext = {{2{b_i[ELEM_W-1]}}, b_i};
      lb_s  = lb_i;

      if (mode_i == MODE_AVG) begin
         pair_s = a_ext + b_ext;
      end else begin
         pair_s = (a_ext > b_ext) ? a_ext : b_ext;
      end

      // Four ELEM_W elements sum into ELEM_W+2 bits without overflow; the
      // arithmetic shift gives floor division by 4.
      if (mode_i == MODE_AVG) begin
         tot_s = lb_s + pair_s;
         res_s = tot_s >>> 2;
      end else begin
         tot_s = (lb_s > pair_s) ? lb_s : pair_s;
         res_s = tot_s;
      end

      pair_o = pair_s;
      out_o  = ELEM_W'(res_s);
   end

endmodule

// File: rtl/pool2d_stream.sv
// pool2d_stream
//   2x2 stride-2 max/average pooling over a row-major AXI-Stream pixel
//   frame, LANES = DATA_W/ELEM_W signed channels per beat (lane 0 in LSBs).
//   Even rows reduce each column pair into a line buffer; odd rows reduce
//   the pair, combine it with the stored partial and emit one pixel.
//   Configured and started over APB.
//
// Ports
//   CLK, RESET            : clock, synchronous active-high reset
//   S_AXIS_*              : input pixels (TVALID/TREADY/TDATA/TLAST)
//   M_AXIS_*              : pooled pixels (TVALID/TREADY/TDATA/TKEEP/TLAST)
//   PADDR..PSLVERR        : APB slave (CTRL, WIDTH, HEIGHT, STATUS, CYCLES)
//   DBG_STATE             : current control FSM state (state_t encoding)
//
// Handshake: a beat transfers on a rising edge where TVALID and TREADY are
// both 1. M_AXIS_TVALID, once raised, stays high with TDATA/TLAST unchanged
// until the transfer; S_AXIS_TREADY may drop at any time and is never
// dependent on S_AXIS_TVALID.
module pool2d_stream
   import pool2d_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int ELEM_W    = 8,
   parameter int MAX_WIDTH = 256
)(
   input  logic                CLK,
   input  logic                RESET,
   input  logic                S_AXIS_TVALID,
   output logic                S_AXIS_TREADY,
   input  logic [DATA_W-1:0]   S_AXIS_TDATA,
   input  logic                S_AXIS_TLAST,
   output logic                M_AXIS_TVALID,
   input  logic                M_AXIS_TREADY,
   output logic [DATA_W-1:0]   M_AXIS_TDATA,
   output logic [DATA_W/8-1:0] M_AXIS_TKEEP,
   output logic                M_AXIS_TLAST,
   input  logic [31:0]         PADDR,
   input  logic                PSEL,
   input  logic                PENABLE,
   input  logic                PWRITE,
   input  logic [31:0]         PWDATA,
   output logic [31:0]         PRDATA,
   output logic                PREADY,
   output logic                PSLVERR,
   output logic [1:0]          DBG_STATE
);

   localparam int LANES    = DATA_W / ELEM_W;
   localparam int LW       = ELEM_W + 2;
   localparam int LB_DEPTH = MAX_WIDTH / 2;
   localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
   localparam logic [15:0] MAX_W16 = 16'(MAX_WIDTH);

   // Shadow (APB-visible) configuration
   logic              mode_q;
   logic [15:0]       width_q;
   logic [15:0]       height_q;
   // Configuration of the frame in flight
   logic              run_mode_q;
   logic [15:0]       run_w_q;
   logic [15:0]       run_h_q;

   state_t            state_q;
   logic [15:0]       col_q;
   logic [15:0]       row_q;
   logic [15:0]       col_d;
   logic [15:0]       row_d;
   logic [DATA_W-1:0] pix0_q;       // even-column pixel awaiting its pair

   logic              m_valid_q;
   logic [DATA_W-1:0] m_data_q;
   logic              m_last_q;

   logic              done_q;
   logic              cfg_err_q;
   logic              tlast_err_q;
   logic [31:0]       cycles_q;

   logic [LANES*LW-1:0] lb_q [LB_DEPTH];
   logic [LANES*LW-1:0] lb_rd;
   logic [LANES*LW-1:0] pair_vec;
   logic [DATA_W-1:0]   final_vec;

   logic apb_wr;
   logic start_req;
   logic cfg_ok;
   logic busy;
   logic s_ready;
   logic accept;
   logic col_last;
   logic row_last;
   logic pix_last;
   logic pair_hit;
   logic out_hit;
   logic m_pop;
   logic unused_bits;

   assign unused_bits = ^{PADDR[31:8], PWDATA[31:16]};

   // ------------------------------------------------------------------
   // Combinational control
   // ------------------------------------------------------------------
   always_comb begin
      apb_wr    = PSEL & PENABLE & PWRITE;
      start_req = apb_wr && (PADDR[7:0] == REG_CTRL) && PWDATA[0];
      cfg_ok    = cfg_valid(width_q, height_q, MAX_W16);
      busy      = (state_q != ST_IDLE);
      // Accept input only if the output slot is free or freeing this cycle.
      s_ready   = (state_q == ST_RUN) && (!m_valid_q || M_AXIS_TREADY);
      accept    = S_AXIS_TVALID && s_ready;
      col_last  = (col_q == run_w_q - 16'd1);
      row_last  = (row_q == run_h_q - 16'd1);
      pix_last  = col_last && row_last;
      pair_hit  = accept && col_q[0];
      out_hit   = pair_hit && row_q[0];
      m_pop     = m_valid_q && M_AXIS_TREADY;

      col_d = col_q + 16'd1;
      row_d = row_q;
      if (col_last) begin
         col_d = 16'd0;
         row_d = row_last ? 16'd0 : row_q + 16'd1;
      end
   end

   assign lb_rd = lb_q[col_q[LB_AW:1]];

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      pool2d_lane #(
         .ELEM_W (ELEM_W)
      ) u_lane (
         .mode_i (run_mode_q),
         .a_i    (pix0_q[l*ELEM_W +: ELEM_W]),
         .b_i    (S_AXIS_TDATA[l*ELEM_W +: ELEM_W]),
         .lb_i   (lb_rd[l*LW +: LW]),
         .pair_o (pair_vec[l*LW +: LW]),
         .out_o  (final_vec[l*ELEM_W +: ELEM_W])
      );
   end

   // Line buffer holds one partial per column pair of the last even row.
   // Contents are not reset; every entry is rewritten before it is read.
   always_ff @(posedge CLK) begin
      if (pair_hit && !row_q[0]) begin
         lb_q[col_q[LB_AW:1]] <= pair_vec;
      end
   end

   // ------------------------------------------------------------------
   // FSM, counters, output register, APB registers
   // ------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q     <= ST_IDLE;
         mode_q      <= MODE_MAX;
         width_q     <= 16'd0;
         height_q    <= 16'd0;
         run_mode_q  <= MODE_MAX;
         run_w_q     <= 16'd0;
         run_h_q     <= 16'd0;
         col_q       <= 16'd0;
         row_q       <= 16'd0;
         pix0_q      <= '0;
         m_valid_q   <= 1'b0;
         m_data_q    <= '0;
         m_last_q    <= 1'b0;
         done_q      <= 1'b0;
         cfg_err_q   <= 1'b0;
         tlast_err_q <= 1'b0;
         cycles_q    <= 32'd0;
      end else begin
         // Shadow registers are always writable; the running frame uses
         // its own latched copy.
         if (apb_wr) begin
            case (PADDR[7:0])
               REG_CTRL:   mode_q   <= PWDATA[1];
               REG_WIDTH:  width_q  <= PWDATA[15:0];
               REG_HEIGHT: height_q <= PWDATA[15:0];
               default: ;
            endcase
         end

         if (busy) begin
            cycles_q <= cycles_q + 32'd1;
         end

         // A new result takes priority over the pop, giving back-to-back
         // output without a bubble.
         if (out_hit) begin
            m_valid_q <= 1'b1;
            m_data_q  <= final_vec;
            m_last_q  <= pix_last;
         end else if (m_pop) begin
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
         end

         if (accept) begin
            if (!col_q[0]) begin
               pix0_q <= S_AXIS_TDATA;
            end
            if (S_AXIS_TLAST != pix_last) begin
               tlast_err_q <= 1'b1;
            end
            col_q <= col_d;
            row_q <= row_d;
         end

         case (state_q)
            ST_IDLE: begin
               if (start_req) begin
                  if (cfg_ok) begin
                     run_mode_q  <= PWDATA[1];
                     run_w_q     <= width_q;
                     run_h_q     <= height_q;
                     col_q       <= 16'd0;
                     row_q       <= 16'd0;
                     cycles_q    <= 32'd0;
                     done_q      <= 1'b0;
                     tlast_err_q <= 1'b0;
                     cfg_err_q   <= 1'b0;
                     state_q     <= ST_RUN;
                  end else begin
                     cfg_err_q <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (accept && pix_last) begin
                  state_q <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (m_pop && m_last_q) begin
                  done_q  <= 1'b1;
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // APB read mux and outputs
   // ------------------------------------------------------------------
   always_comb begin
      PRDATA = 32'd0;
      case (PADDR[7:0])
         REG_CTRL:   PRDATA = {30'd0, mode_q, 1'b0};
         REG_WIDTH:  PRDATA = {16'd0, width_q};
         REG_HEIGHT: PRDATA = {16'd0, height_q};
         REG_STATUS: PRDATA = {28'd0, tlast_err_q, cfg_err_q, done_q, busy};
         REG_CYCLES: PRDATA = cycles_q;
         default:    PRDATA = 32'd0;
      endcase
   end

   assign PREADY        = 1'b1;
   assign PSLVERR       = 1'b0;
   assign S_AXIS_TREADY = s_ready;
   assign M_AXIS_TVALID = m_valid_q;
   assign M_AXIS_TDATA  = m_data_q;
   assign M_AXIS_TLAST  = m_last_q;
   assign M_AXIS_TKEEP  = '1;
   assign DBG_STATE     = state_q;

endmodule

// File: tb/tb_pool2d_stream.sv
// tb_pool2d_stream
//   Self-checking bench for pool2d_stream: APB driver tasks, a stream
//   driver, a reference model that pools the stored frame with plain
//   integer arithmetic into an expected queue, and a negedge monitor that
//   scores every output beat and the stall-hold behaviour.
module tb_pool2d_stream;
   import pool2d_pkg::*;

   localparam int DATA_W    = 32;
   localparam int ELEM_W    = 8;
   localparam int LANES     = DATA_W / ELEM_W;
   localparam int MAX_WIDTH = 256;

   logic                CLK = 1'b0;
   logic                RESET;
   logic                S_AXIS_TVALID;
   logic                S_AXIS_TREADY;
   logic [DATA_W-1:0]   S_AXIS_TDATA;
   logic                S_AXIS_TLAST;
   logic                M_AXIS_TVALID;
   logic                M_AXIS_TREADY;
   logic [DATA_W-1:0]   M_AXIS_TDATA;
   logic [DATA_W/8-1:0] M_AXIS_TKEEP;
   logic                M_AXIS_TLAST;
   logic [31:0]         PADDR;
   logic                PSEL;
   logic                PENABLE;
   logic                PWRITE;
   logic [31:0]         PWDATA;
   logic [31:0]         PRDATA;
   logic                PREADY;
   logic                PSLVERR;
   logic [1:0]          DBG_STATE;

   pool2d_stream #(
      .DATA_W    (DATA_W),
      .ELEM_W    (ELEM_W),
      .MAX_WIDTH (MAX_WIDTH)
   ) dut (
      .CLK           (CLK),
      .RESET         (RESET),
      .S_AXIS_TVALID (S_AXIS_TVALID),
      .S_AXIS_TREADY (S_AXIS_TREADY),
      .S_AXIS_TDATA  (S_AXIS_TDATA),
      .S_AXIS_TLAST  (S_AXIS_TLAST),
      .M_AXIS_TVALID (M_AXIS_TVALID),
      .M_AXIS_TREADY (M_AXIS_TREADY),
      .M_AXIS_TDATA  (M_AXIS_TDATA),
      .M_AXIS_TKEEP  (M_AXIS_TKEEP),
      .M_AXIS_TLAST  (M_AXIS_TLAST),
      .PADDR         (PADDR),
      .PSEL          (PSEL),
      .PENABLE       (PENABLE),
      .PWRITE        (PWRITE),
      .PWDATA        (PWDATA),
      .PRDATA        (PRDATA),
      .PREADY        (PREADY),
      .PSLVERR       (PSLVERR),
      .DBG_STATE     (DBG_STATE)
   );

   // ---------------- clock / cycle counter ----------------
   always #5 CLK = ~CLK;

   int cyc_cnt = 0;
   always @(posedge CLK) cyc_cnt <= cyc_cnt + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, cycle %0d", cyc_cnt);
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   int                n_checks = 0;
   int                n_fail   = 0;
   logic [DATA_W:0]   exp_q[$];
   logic [DATA_W-1:0] pix [0:1023];
   int                wr_edge   = 0;
   int                last_edge = 0;
   int                out_cnt   = 0;
   logic              rand_ready = 1'b0;
   logic [DATA_W-1:0] last_out = '0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc_cnt);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int elem(input logic [DATA_W-1:0] p, input int l);
      logic [ELEM_W-1:0] b;
      b = p[l*ELEM_W +: ELEM_W];
      return int'($signed(b));
   endfunction

   function automatic logic [DATA_W-1:0] pool_px(input int w, input int r, input int c, input logic mode);
      logic [DATA_W-1:0] res;
      int v[4];
      int s, m;
      res = '0;
      for (int l = 0; l < LANES; l++) begin
         v[0] = elem(pix[(2*r)*w + 2*c], l);
         v[1] = elem(pix[(2*r)*w + 2*c + 1], l);
         v[2] = elem(pix[(2*r+1)*w + 2*c], l);
         v[3] = elem(pix[(2*r+1)*w + 2*c + 1], l);
         if (mode) begin
            s = v[0] + v[1] + v[2] + v[3];
            m = s >>> 2;
         end else begin
            m = v[0];
            for (int k = 1; k < 4; k++) if (v[k] > m) m = v[k];
         end
         res[l*ELEM_W +: ELEM_W] = m[ELEM_W-1:0];
      end
      return res;
   endfunction

   task automatic build_model(input int w, input int h, input logic mode);
      for (int r = 0; r < h/2; r++)
         for (int c = 0; c < w/2; c++)
            exp_q.push_back({(r == h/2-1) && (c == w/2-1), pool_px(w, r, c, mode)});
   endtask

   // ---------------- monitor ----------------
   initial begin
      logic              prev_stall;
      logic [DATA_W:0]   prev_word;
      logic [DATA_W:0]   e;
      prev_stall = 1'b0;
      prev_word  = '0;
      forever begin
         @(negedge CLK);
         if (RESET) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               check_eq("hold_tvalid", M_AXIS_TVALID, 1);
               check_eq("hold_tdata_tlast", {M_AXIS_TLAST, M_AXIS_TDATA}, prev_word);
            end
            if (M_AXIS_TVALID && M_AXIS_TREADY) begin
               out_cnt++;
               check_eq("beat_expected", 64'(exp_q.size() != 0), 1);
               check_eq("tkeep", M_AXIS_TKEEP, 4'hF);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  check_eq("tdata", M_AXIS_TDATA, e[DATA_W-1:0]);
                  check_eq("tlast", M_AXIS_TLAST, e[DATA_W]);
               end
               last_out = M_AXIS_TDATA;
               if (M_AXIS_TLAST) last_edge = cyc_cnt + 1;
            end
            prev_stall = M_AXIS_TVALID && !M_AXIS_TREADY;
            prev_word  = {M_AXIS_TLAST, M_AXIS_TDATA};
         end
      end
   end

   // ---------------- M_AXIS_TREADY driver ----------------
   initial begin
      M_AXIS_TREADY = 1'b1;
      forever begin
         @(posedge CLK);
         #1;
         M_AXIS_TREADY = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic apb_write(input logic [7:0] addr, input logic [31:0] data, output int edge_no);
      PADDR = {24'd0, addr}; PWDATA = data; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
      @(posedge CLK); #1;
      PENABLE = 1'b1;
      @(negedge CLK);
      edge_no = cyc_cnt + 1;
      @(posedge CLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
   endtask

   task automatic apb_read(input logic [7:0] addr, output logic [31:0] data);
      PADDR = {24'd0, addr}; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0;
      @(posedge CLK); #1;
      PENABLE = 1'b1;
      @(negedge CLK);
      data = PRDATA;
      @(posedge CLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   task automatic start_frame(input int w, input int h, input logic mode);
      int d;
      apb_write(REG_WIDTH, 32'(w), d);
      apb_write(REG_HEIGHT, 32'(h), d);
      apb_write(REG_CTRL, {30'd0, mode, 1'b1}, wr_edge);
   endtask

   task automatic send_beats(input int w, input int h, input int nbeats, input int bad_last);
      logic hs;
      int   waited;
      for (int i = 0; i < nbeats; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            S_AXIS_TVALID = 1'b0;
            @(posedge CLK); #1;
         end
         S_AXIS_TVALID = 1'b1;
         S_AXIS_TDATA  = pix[i];
         S_AXIS_TLAST  = (bad_last >= 0) ? (i == bad_last) : (i == w*h - 1);
         hs = 1'b0;
         waited = 0;
         while (!hs && waited < 2000) begin
            @(negedge CLK);
            hs = S_AXIS_TREADY;
            @(posedge CLK); #1;
            waited++;
         end
         check_eq("s_beat_accepted", hs, 1);
         if (!hs) break;
      end
      S_AXIS_TVALID = 1'b0;
      S_AXIS_TLAST  = 1'b0;
   endtask

   task automatic run_frame(input int w, input int h, input logic mode, input int bad_last,
                            input bit preset, input bit mid_wr);
      logic [31:0] rd;
      int d;
      int polls;
      if (!preset) for (int i = 0; i < w*h; i++) pix[i] = $urandom;
      out_cnt = 0;
      last_edge = 0;
      build_model(w, h, mode);
      start_frame(w, h, mode);
      if (mid_wr) begin
         fork
            send_beats(w, h, w*h, bad_last);
            begin
               repeat (12) @(posedge CLK);
               #1;
               apb_write(REG_WIDTH, 32'd6, d);
               apb_write(REG_CTRL, {30'd0, ~mode, 1'b1}, d);
            end
         join
      end else begin
         send_beats(w, h, w*h, bad_last);
      end
      rd = '0;
      polls = 0;
      while (!rd[1] && polls < 500) begin
         apb_read(REG_STATUS, rd);
         polls++;
      end
      check_eq("status_done", rd[1], 1);
      check_eq("status_busy", rd[0], 0);
      check_eq("status_cfg_err", rd[2], 0);
      check_eq("status_tlast_err", rd[3], 64'(bad_last >= 0));
      check_eq("outputs_left", exp_q.size(), 0);
      check_eq("output_count", out_cnt, w*h/4);
      apb_read(REG_CYCLES, rd);
      check_eq("cycles", rd, last_edge - wr_edge);
   endtask

   // ---------------- main sequence ----------------
   int cfg_tab[4][2] = '{'{3, 2}, '{MAX_WIDTH + 2, 2}, '{4, 0}, '{4, 3}};
   int max_lane0[8]  = '{1, 5, 2, 3, 4, 0, 7, -8};

   initial begin
      logic [31:0] rd;
      int d, w, h;
      RESET = 1'b1;
      S_AXIS_TVALID = 1'b0; S_AXIS_TDATA = '0; S_AXIS_TLAST = 1'b0;
      PADDR = '0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PWDATA = '0;
      repeat (4) @(posedge CLK);
      #1;
      RESET = 1'b0;

      // Reset state
      @(negedge CLK);
      check_eq("rst_m_tvalid", M_AXIS_TVALID, 0);
      check_eq("rst_s_tready", S_AXIS_TREADY, 0);
      check_eq("rst_state", DBG_STATE, ST_IDLE);
      check_eq("pready", PREADY, 1);
      check_eq("pslverr", PSLVERR, 0);
      @(posedge CLK); #1;
      apb_read(REG_CTRL, rd);   check_eq("rst_ctrl", rd, 0);
      apb_read(REG_WIDTH, rd);  check_eq("rst_width", rd, 0);
      apb_read(REG_HEIGHT, rd); check_eq("rst_height", rd, 0);
      apb_read(REG_STATUS, rd); check_eq("rst_status", rd, 0);
      apb_read(REG_CYCLES, rd); check_eq("rst_cycles", rd, 0);

      // Max pooling, 4x2 with fixed lane-0 values
      for (int i = 0; i < 8; i++) begin
         pix[i] = $urandom;
         pix[i][7:0] = 8'(max_lane0[i]);
      end
      run_frame(4, 2, MODE_MAX, -1, 1, 0);
      check_eq("max_lane0_second", last_out[7:0], 8'd7);

      // Average pooling of -1,-1,-1,-2 rounds toward minus infinity
      pix[0] = 32'hFFFFFFFF; pix[1] = 32'hFFFFFFFF;
      pix[2] = 32'hFFFFFFFF; pix[3] = 32'hFEFEFEFE;
      run_frame(2, 2, MODE_AVG, -1, 1, 0);
      check_eq("avg_negative", last_out, 32'hFEFEFEFE);

      // Invalid geometries
      for (int t = 0; t < 4; t++) begin
         apb_write(REG_WIDTH, 32'(cfg_tab[t][0]), d);
         apb_write(REG_HEIGHT, 32'(cfg_tab[t][1]), d);
         apb_write(REG_CTRL, 32'd1, d);
         apb_read(REG_STATUS, rd);
         check_eq("cfg_err_set", rd[2], 1);
         check_eq("cfg_err_state", DBG_STATE, ST_IDLE);
         S_AXIS_TVALID = 1'b1;
         repeat (3) begin
            @(negedge CLK);
            check_eq("cfg_err_tready", S_AXIS_TREADY, 0);
         end
         @(posedge CLK); #1;
         S_AXIS_TVALID = 1'b0;
      end

      // 8x4 with output backpressure and shadow writes mid-frame
      rand_ready = 1'b1;
      run_frame(8, 4, MODE_MAX, -1, 0, 1);
      apb_read(REG_WIDTH, rd); check_eq("shadow_width", rd, 6);
      apb_read(REG_CTRL, rd);  check_eq("shadow_ctrl", rd, 2);

      // Misplaced input TLAST at beat 5 of 16
      run_frame(8, 2, 1'($urandom_range(0, 1)), 4, 0, 0);

      // Widest row
      run_frame(MAX_WIDTH, 2, MODE_AVG, -1, 0, 0);

      // Random frames
      for (int k = 0; k < 4; k++) begin
         w = 2 * $urandom_range(1, 8);
         h = 2 * $urandom_range(1, 4);
         rand_ready = 1'($urandom_range(0, 1));
         run_frame(w, h, 1'($urandom_range(0, 1)), -1, 0, 0);
      end

      // Reset in the middle of row 1, then a fresh frame
      rand_ready = 1'b0;
      for (int i = 0; i < 32; i++) pix[i] = $urandom;
      build_model(8, 4, MODE_MAX);
      start_frame(8, 4, MODE_MAX);
      send_beats(8, 4, 10, -1);
      RESET = 1'b1;
      @(posedge CLK); #1;
      RESET = 1'b0;
      @(negedge CLK);
      check_eq("abort_m_tvalid", M_AXIS_TVALID, 0);
      check_eq("abort_s_tready", S_AXIS_TREADY, 0);
      check_eq("abort_state", DBG_STATE, ST_IDLE);
      exp_q.delete();
      @(posedge CLK); #1;
      apb_read(REG_STATUS, rd); check_eq("abort_status", rd, 0);
      apb_read(REG_CYCLES, rd); check_eq("abort_cycles", rd, 0);
      apb_read(REG_WIDTH, rd);  check_eq("abort_width", rd, 0);
      repeat (20) @(posedge CLK);
      #1;
      run_frame(8, 4, MODE_AVG, -1, 0, 0);

      repeat (5) @(posedge CLK);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pool2d_stream.md
POOL2D_STREAM -- requirements
Module: pool2d_stream

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the S/M AXIS TDATA width in bits.
REQ-002 Parameter ELEM_W, default 8, SHALL set the signed element width; LANES = DATA_W/ELEM_W channels are packed per beat, lane 0 in LSBs.
REQ-003 Parameter MAX_WIDTH, default 256, SHALL set the maximum row width in pixels, which is also the line-buffer sizing bound.
REQ-004 Port CLK, in, 1: the single clock; all logic is rising-edge.
REQ-005 Port RESET, in, 1: synchronous, active-high reset.
REQ-006 Ports S_AXIS_TVALID in 1, S_AXIS_TREADY out 1, S_AXIS_TDATA in DATA_W, S_AXIS_TLAST in 1: input pixel stream, row-major, one pixel per beat.
REQ-007 Ports M_AXIS_TVALID out 1, M_AXIS_TREADY in 1, M_AXIS_TDATA out DATA_W, M_AXIS_TKEEP out DATA_W/8, M_AXIS_TLAST out 1: pooled output stream.
REQ-008 Ports PADDR in 32, PSEL in 1, PENABLE in 1, PWRITE in 1, PWDATA in 32, PRDATA out 32, PREADY out 1, PSLVERR out 1: APB register slave.

Function
REQ-009 PREADY SHALL be constant 1; PSLVERR SHALL be constant 0; a write occurs on PSEL&PENABLE&PWRITE; PRDATA SHALL be combinational from PADDR[7:0].
REQ-010 Registers: 0x00 CTRL (bit0 START, write-1 pulse, reads 0; bit1 MODE, 0=max, 1=avg); 0x04 WIDTH[15:0]; 0x08 HEIGHT[15:0]; 0x0C STATUS (bit0 busy, bit1 done, bit2 cfg_err, bit3 tlast_err; RO); 0x10 CYCLES (RO); other addresses read 0.
REQ-011 The FSM states SHALL be IDLE, RUN and DRAIN.
REQ-012 START in IDLE with WIDTH and HEIGHT even, nonzero, and WIDTH<=MAX_WIDTH SHALL latch MODE/WIDTH/HEIGHT, clear done and tlast_err, zero the counters, and enter RUN next cycle.
REQ-013 START in IDLE with an invalid configuration SHALL set cfg_err and remain in IDLE; a valid START SHALL clear cfg_err.
REQ-014 START while in RUN or DRAIN SHALL be ignored; register writes in those states SHALL update the shadow registers only and SHALL not affect the current frame.
REQ-015 Pooling SHALL be 2x2, stride 2, per lane independently; the output frame SHALL be WIDTH/2 x HEIGHT/2 pixels.
REQ-016 Max mode SHALL take the signed maximum of the 4 elements.
REQ-017 Avg mode SHALL form a signed sum of width ELEM_W+2, arithmetic-shift it right by 2 (floor), and truncate to ELEM_W; example: -1,-1,-1,-2 gives -2.
REQ-018 On even rows, each column pair SHALL be reduced (max, or sum) and written to the line buffer at index col/2.
REQ-019 On odd rows, each column pair SHALL be reduced, combined with the line-buffer entry, and then produce one output.
REQ-020 S_AXIS_TREADY SHALL be 1 only in RUN and only when the output register is empty or M_AXIS_TREADY is 1.
REQ-021 Output SHALL be a single registered stage; latency SHALL be 1 cycle from the accepting beat (odd row, odd column) to M_AXIS_TVALID.
REQ-022 M_AXIS_TVALID/TDATA/TLAST SHALL hold stable while TVALID=1 and TREADY=0.
REQ-023 M_AXIS_TKEEP SHALL be all ones; M_AXIS_TLAST SHALL be 1 only on the final output pixel of the frame.
REQ-024 Column and row counters SHALL wrap at WIDTH-1 and HEIGHT-1; after the last input beat the FSM SHALL enter DRAIN.
REQ-025 DRAIN SHALL return to IDLE on the handshake of the TLAST output and set done (sticky until the next valid START).
REQ-026 Input S_AXIS_TLAST SHALL be checked on every accepted beat; a mismatch with the last-pixel position SHALL set tlast_err. Processing SHALL follow the counters regardless.
REQ-027 CYCLES SHALL count every clock in RUN or DRAIN, and SHALL hold its value in IDLE.
REQ-028 Simultaneous output handshake and new result in the same cycle SHALL load the new result with no bubble.

Reset
REQ-029 RESET SHALL force IDLE, all outputs and TVALIDs to 0, and registers CTRL/WIDTH/HEIGHT/STATUS/CYCLES to 0.
REQ-030 Line-buffer contents SHALL not be reset.
REQ-031 RESET asserted mid-frame SHALL abort the frame; no further M beats SHALL be issued.

Structure
REQ-032 Package pool2d_pkg SHALL hold the state enum, the register offsets, and the MODE encodings.
REQ-033 One sub-module, pool2d_lane, SHALL perform the per-lane reduce (max/sum, avg shift) and SHALL be instantiated LANES times.
REQ-034 The line buffer SHALL be an inferred MAX_WIDTH/2 x (LANES*(ELEM_W+2)) register array.

Verification
REQ-035 Max mode, W=4, H=2, lane0 inputs 1,5,2,3 / 4,0,7,-8 -> two outputs, 5 then 7; TLAST on the second; done=1.
REQ-036 Avg mode, 2x2 of -1,-1,-1,-2 on all lanes -> TDATA 0xFEFEFEFE.
REQ-037 W=3 START -> cfg_err=1, state IDLE, TREADY stays 0.
REQ-038 W=8, H=4 with M_AXIS_TREADY toggling 50% -> 8 outputs in order, no loss or duplication, TDATA held while stalled.
REQ-039 Input TLAST asserted at beat 5 of a 16-beat frame -> tlast_err=1, frame still completes with 4 outputs.
REQ-040 RESET pulse during row 1 -> TVALID=0 next cycle, STATUS=0; a following valid START processes a fresh frame correctly.
